// File: rtl/csidh_host_if_if.sv
// Host-side word stream between a controller and the CSIDH host front end:
// input words toward the core and result words back to the host.
interface csidh_host_if_if #(
  parameter int word_size = 32
);
  logic [word_size-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [word_size-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 out_invalid;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_invalid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_invalid
  );
endinterface

// File: rtl/csidh_host_if.sv
// Word-serial loader/unloader around the CSIDH core: loads A and the private
// vector, pulses the core reset, times the run and streams A_out back.
module csidh_host_if #(
  parameter int N         = 1024,
  parameter int word_size = 32,
  parameter int KEY_BITS  = 520,
  parameter int RST_HOLD  = 10
) (
  input  logic                clk,
  input  logic                rst,
  csidh_host_if_if.slave      host,
  output logic [47:0]         run_cycles,
  output logic                busy,
  output logic                core_rst,
  output logic [N-1:0]        core_A_in,
  output logic [KEY_BITS-1:0] core_private,
  input  logic [N-1:0]        core_A_out,
  input  logic                core_done,
  input  logic                core_invalid
);

  localparam int NA  = N / word_size;
  localparam int NK  = (KEY_BITS + word_size - 1) / word_size;
  localparam int CW  = $clog2(((NA > NK) ? NA : NK) + 1);
  localparam int HW  = $clog2(RST_HOLD + 1);
  localparam int AIW = $clog2(N);
  localparam int KIW = $clog2(KEY_BITS);

  typedef enum logic [2:0] {LOAD_A, LOAD_K, HOLD, RUN, SEND} state_t;

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r;
  logic [HW-1:0]       hold_cnt_r;
  logic [47:0]         run_cnt_r;
  logic [47:0]         run_cycles_r;
  logic [N-1:0]        shift_r;
  logic [N-1:0]        core_a_in_r;
  logic [KEY_BITS-1:0] core_private_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic                out_invalid_r;
  logic                busy_r;
  logic                core_rst_r;
  logic                acc_s;
  logic                xfer_s;
  logic                hold_done_s;

  function automatic logic [47:0] sat_inc(input logic [47:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 48'd1;
  endfunction

  assign acc_s       = host.in_valid & in_ready_r;
  assign xfer_s      = out_valid_r & host.out_ready;
  assign hold_done_s = (hold_cnt_r == HW'(RST_HOLD - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= LOAD_A;
    else      state_r <= state_s;
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD_A:  if (acc_s && cnt_r == CW'(NA - 1)) state_s = LOAD_K; else state_s = state_r;
      LOAD_K:  if (acc_s && cnt_r == CW'(NK - 1)) state_s = HOLD;   else state_s = state_r;
      HOLD:    if (hold_done_s)                   state_s = RUN;    else state_s = state_r;
      RUN:     if (core_done)                     state_s = SEND;   else state_s = state_r;
      SEND:    if (xfer_s && cnt_r == CW'(NA - 1)) state_s = LOAD_A; else state_s = state_r;
      default: state_s = LOAD_A;
    endcase
  end

  // Datapath, counters and registered handshake/core controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r          <= '0;
      hold_cnt_r     <= '0;
      run_cnt_r      <= 48'd0;
      run_cycles_r   <= 48'd0;
      shift_r        <= '0;
      core_a_in_r    <= '0;
      core_private_r <= '0;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      out_invalid_r  <= 1'b0;
      busy_r         <= 1'b0;
      core_rst_r     <= 1'b1;
    end else begin
      // Controls follow the upcoming state so they never lag it by a cycle.
      in_ready_r <= (state_s == LOAD_A) || (state_s == LOAD_K);
      busy_r     <= (state_s == HOLD) || (state_s == RUN);
      core_rst_r <= (state_s != RUN);
      case (state_r)
        LOAD_A: begin
          if (acc_s) begin
            core_a_in_r[AIW'(int'(cnt_r) * word_size) +: word_size] <= host.in_data;
            cnt_r <= (cnt_r == CW'(NA - 1)) ? CW'(0) : cnt_r + CW'(1);
          end
        end
        LOAD_K: begin
          if (acc_s) begin
            // Bits of the top word beyond the key width are dropped.
            for (int b = 0; b < word_size; b++) begin
              if ((int'(cnt_r) * word_size + b) < KEY_BITS) begin
                core_private_r[KIW'(int'(cnt_r) * word_size + b)] <= host.in_data[b];
              end
            end
            cnt_r      <= (cnt_r == CW'(NK - 1)) ? CW'(0) : cnt_r + CW'(1);
            hold_cnt_r <= HW'(0);
          end
        end
        HOLD: begin
          hold_cnt_r <= hold_cnt_r + HW'(1);
          if (hold_done_s) run_cnt_r <= 48'd0;
        end
        RUN: begin
          if (core_done) begin
            shift_r       <= core_A_out;
            out_invalid_r <= core_invalid;
            run_cycles_r  <= run_cnt_r;
            cnt_r         <= CW'(0);
            out_valid_r   <= 1'b1;
            out_last_r    <= (NA == 1);
          end else begin
            run_cnt_r <= sat_inc(run_cnt_r);
          end
        end
        SEND: begin
          if (xfer_s) begin
            shift_r <= shift_r >> word_size;
            if (cnt_r == CW'(NA - 1)) begin
              cnt_r       <= CW'(0);
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              cnt_r      <= cnt_r + CW'(1);
              out_last_r <= (cnt_r == CW'(NA - 2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign host.in_ready    = in_ready_r;
  assign host.out_data    = shift_r[word_size-1:0];
  assign host.out_valid   = out_valid_r;
  assign host.out_last    = out_last_r;
  assign host.out_invalid = out_invalid_r;
  assign run_cycles       = run_cycles_r;
  assign busy             = busy_r;
  assign core_rst         = core_rst_r;
  assign core_A_in        = core_a_in_r;
  assign core_private     = core_private_r;

endmodule

// File: tb/tb_csidh_host_if.sv
// Randomized bench for csidh_host_if: a transaction-level model tracks loaded
// words, hold/run timing and the expected result queue, checked every cycle.
module tb_csidh_host_if;
  localparam int N = 1024, W = 32, KB = 520, RH = 10, NA = 32, NK = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csidh_host_if_if #(.word_size(W)) host();
  logic [47:0]   run_cycles;
  logic          busy, core_rst;
  logic [N-1:0]  core_A_in;
  logic [KB-1:0] core_private;
  logic [N-1:0]  core_A_out;
  logic          core_done, core_invalid;

  csidh_host_if #(.N(N), .word_size(W), .KEY_BITS(KB), .RST_HOLD(RH)) dut (
    .clk(clk), .rst(rst), .host(host.slave),
    .run_cycles(run_cycles), .busy(busy), .core_rst(core_rst),
    .core_A_in(core_A_in), .core_private(core_private),
    .core_A_out(core_A_out), .core_done(core_done), .core_invalid(core_invalid)
  );

  // Core stand-in: done appears on the lat-th cycle after its reset drops.
  int lat = 500;
  int core_cnt = 0;
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else          core_cnt <= core_cnt + 1;
  end
  assign core_done = !core_rst && (core_cnt == lat - 1);

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] a_words [NA];
  logic [31:0] k_words [NK];
  logic [31:0] q [$];
  int          acc, hold_left, run_k, n_acc = 0;
  bit          running, ready_ok, exp_inv, prev_stall, prev_last;
  logic [47:0] exp_run;
  logic [31:0] prev_data;

  function automatic logic [N-1:0] model_a();
    logic [N-1:0] v;
    for (int i = 0; i < NA; i++) v[i*32 +: 32] = a_words[i];
    return v;
  endfunction

  function automatic logic [KB-1:0] model_k();
    logic [NK*32-1:0] v;
    for (int i = 0; i < NK; i++) v[i*32 +: 32] = k_words[i];
    return v[KB-1:0];
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", host.in_ready == 1'b0, 64'(host.in_ready), 64'd0);
      chk("rst_out_valid", host.out_valid == 1'b0 && host.out_last == 1'b0, 64'(host.out_valid), 64'd0);
      chk("rst_out_invalid", host.out_invalid == 1'b0, 64'(host.out_invalid), 64'd0);
      chk("rst_run_cycles", run_cycles == 48'd0, 64'(run_cycles), 64'd0);
      chk("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
      chk("rst_core_rst", core_rst == 1'b1, 64'(core_rst), 64'd1);
      chk("rst_core_a_in", core_A_in == '0, core_A_in[63:0], 64'd0);
      chk("rst_core_private", core_private == '0, core_private[63:0], 64'd0);
      for (int i = 0; i < NA; i++) a_words[i] = 32'd0;
      for (int i = 0; i < NK; i++) k_words[i] = 32'd0;
      q.delete();
      acc = 0; hold_left = 0; run_k = 0; running = 1'b0; ready_ok = 1'b0;
      exp_inv = 1'b0; exp_run = 48'd0; prev_stall = 1'b0;
    end else begin
      chk("in_ready", host.in_ready == (hold_left == 0 && !running && q.size() == 0 && ready_ok),
          64'(host.in_ready), 64'(hold_left == 0 && !running && q.size() == 0 && ready_ok));
      chk("out_valid", host.out_valid == (q.size() != 0), 64'(host.out_valid), 64'(q.size() != 0));
      chk("busy", busy == (hold_left > 0 || running), 64'(busy), 64'(hold_left > 0 || running));
      chk("core_rst", core_rst == !running, 64'(core_rst), 64'(!running));
      chk("core_a_in", core_A_in == model_a(), core_A_in[63:0], model_a()[63:0]);
      chk("core_private", core_private == model_k(), core_private[KB-1:KB-64], model_k()[KB-1:KB-64]);
      chk("run_cycles", run_cycles == exp_run, 64'(run_cycles), 64'(exp_run));
      chk("out_invalid", host.out_invalid == exp_inv, 64'(host.out_invalid), 64'(exp_inv));
      if (host.out_valid && q.size() > 0) begin
        chk("out_data", host.out_data == q[0], 64'(host.out_data), 64'(q[0]));
        chk("out_last", host.out_last == (q.size() == 1), 64'(host.out_last), 64'(q.size() == 1));
      end
      if (prev_stall) begin
        chk("stall_data", host.out_data == prev_data && host.out_last == prev_last,
            64'(host.out_data), 64'(prev_data));
      end
      prev_stall = host.out_valid && !host.out_ready;
      prev_data  = host.out_data;
      prev_last  = host.out_last;
      ready_ok   = 1'b1;
      if (host.in_valid && host.in_ready) begin
        if (acc < NA) a_words[acc] = host.in_data;
        else          k_words[acc - NA] = host.in_data;
        acc++;
        n_acc++;
        if (acc == NA + NK) begin
          acc = 0;
          hold_left = RH;
        end
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          running = 1'b1;
          run_k = 0;
        end
      end else if (running) begin
        if (core_done) begin
          running = 1'b0;
          exp_run = 48'(run_k);
          exp_inv = core_invalid;
          for (int i = 0; i < NA; i++) q.push_back(core_A_out[i*32 +: 32]);
        end else begin
          run_k++;
        end
      end
      if (host.out_valid && host.out_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  logic [31:0] src [NA+NK];
  int          nx;
  logic [31:0] first_w, last_w;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_src(input bit rnd);
    for (int i = 0; i < NA + NK; i++) src[i] = rnd ? $urandom : 32'd0;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic load(input int first, input int last, input bit gaps, input bit keep_valid);
    bit got;
    int t;
    for (int w = first; w <= last; w++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          host.in_valid = 1'b0;
          host.in_data  = $urandom;
          step();
        end
      end
      host.in_valid = 1'b1;
      host.in_data  = src[w];
      t = 0;
      do begin
        @(negedge clk);
        got = host.in_ready;
        step();
        t++;
      end while (!got && t < 200);
      if (!got) chk("load_timeout", 1'b0, 64'(w), 64'(w));
    end
    if (!keep_valid) host.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: toggling, 2: random; pat selects a fixed A_out pattern
  task automatic drain(input int mode, input bit inv, input bit pat, input int max_xfer);
    bit fin;
    int t;
    nx = 0; fin = 1'b0; t = 0;
    host.out_ready = 1'b0;
    while (!fin && nx < max_xfer && t < 3000) begin
      case (mode)
        0:       host.out_ready = 1'b1;
        1:       host.out_ready = ~host.out_ready;
        default: host.out_ready = 1'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < NA; i++)
        core_A_out[i*32 +: 32] = (pat && !core_rst) ? (32'hA500_0000 | 32'(i)) : $urandom;
      core_invalid = core_rst ? 1'($urandom_range(0, 1)) : inv;
      @(negedge clk);
      if (host.out_valid && host.out_ready) begin
        if (nx == 0) first_w = host.out_data;
        last_w = host.out_data;
        nx++;
        if (host.out_last) fin = 1'b1;
      end
      step();
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 1'b0, 64'(nx), 64'(NA));
    host.out_ready = 1'b0;
  endtask

  initial begin
    int base;
    host.in_valid = 1'b0; host.in_data = 32'd0; host.out_ready = 1'b0;
    core_A_out = '0; core_invalid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // 1: zero A, low 64 key bits = 0x1111..., 500-cycle core
    fill_src(1'b0);
    src[NA] = 32'h1111_1111; src[NA+1] = 32'h1111_1111;
    lat = 500;
    load(0, NA + NK - 1, 1'b0, 1'b0);
    chk("t1_key_low", core_private[63:0] == 64'h1111_1111_1111_1111, core_private[63:0], 64'h1111_1111_1111_1111);
    chk("t1_a_zero", core_A_in == '0, core_A_in[63:0], 64'd0);
    drain(0, 1'b0, 1'b1, 1000);
    chk("t1_words", nx == NA, 64'(nx), 64'(NA));
    chk("t1_run_cycles", run_cycles == 48'd499, 64'(run_cycles), 64'd499);
    chk("t1_first_word", first_w == 32'hA500_0000, 64'(first_w), 64'hA500_0000);
    chk("t1_last_word", last_w == 32'hA500_001F, 64'(last_w), 64'hA500_001F);

    // 2: top key word all ones, only 8 bits survive
    fill_src(1'b1);
    src[NA+NK-1] = 32'hFFFF_FFFF;
    lat = $urandom_range(2, 60);
    load(0, NA + NK - 1, 1'b1, 1'b0);
    chk("t2_key_top", core_private[519:512] == 8'hFF, 64'(core_private[519:512]), 64'hFF);
    drain(2, 1'b0, 1'b0, 1000);
    chk("t2_words", nx == NA, 64'(nx), 64'(NA));

    // 3: toggling out_ready, done on the very first run cycle
    fill_src(1'b1);
    lat = 1;
    load(0, NA + NK - 1, 1'b1, 1'b0);
    drain(1, 1'b0, 1'b0, 1000);
    chk("t3_words", nx == NA, 64'(nx), 64'(NA));
    chk("t3_run_cycles", run_cycles == 48'd0, 64'(run_cycles), 64'd0);

    // 4: invalid flag captured, held until the next capture
    fill_src(1'b1);
    lat = 20;
    load(0, NA + NK - 1, 1'b1, 1'b0);
    drain(2, 1'b1, 1'b0, 1000);
    chk("t4_invalid_set", host.out_invalid == 1'b1, 64'(host.out_invalid), 64'd1);
    fill_src(1'b1);
    load(0, NA + NK - 1, 1'b1, 1'b0);
    chk("t4_invalid_held", host.out_invalid == 1'b1, 64'(host.out_invalid), 64'd1);
    drain(0, 1'b0, 1'b0, 1000);
    chk("t4_invalid_clr", host.out_invalid == 1'b0, 64'(host.out_invalid), 64'd0);

    // 5: reset during RUN, then during SEND word 5, then a fresh session
    fill_src(1'b1);
    lat = 300;
    load(0, NA + NK - 1, 1'b0, 1'b0);
    repeat (50) step();
    chk("t5_busy_run", busy == 1'b1 && core_rst == 1'b0, 64'(busy), 64'd1);
    pulse_rst();
    chk("t5_a_cleared", core_A_in == '0, core_A_in[63:0], 64'd0);
    fill_src(1'b1);
    lat = 30;
    load(0, NA + NK - 1, 1'b1, 1'b0);
    drain(0, 1'b0, 1'b0, 5);
    pulse_rst();
    chk("t5_out_cleared", host.out_valid == 1'b0 && run_cycles == 48'd0, 64'(run_cycles), 64'd0);
    fill_src(1'b1);
    src[0] = 32'hDEAD_BEEF;
    load(0, 0, 1'b0, 1'b0);
    chk("t5_word0", core_A_in[31:0] == 32'hDEAD_BEEF, 64'(core_A_in[31:0]), 64'hDEAD_BEEF);
    load(1, NA + NK - 1, 1'b1, 1'b0);
    drain(2, 1'b0, 1'b0, 1000);
    chk("t5_words", nx == NA, 64'(nx), 64'(NA));

    // 6: in_valid left high into HOLD/RUN
    fill_src(1'b1);
    lat = 40;
    base = n_acc;
    load(0, NA + NK - 1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      host.in_data = $urandom;
      step();
    end
    host.in_valid = 1'b0;
    chk("t6_accepted", (n_acc - base) == NA + NK, 64'(n_acc - base), 64'(NA + NK));
    drain(0, 1'b0, 1'b0, 1000);

    // Extra random sessions
    for (int s = 0; s < 3; s++) begin
      fill_src(1'b1);
      lat = $urandom_range(1, 80);
      load(0, NA + NK - 1, 1'b1, 1'b0);
      drain($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 1000);
      chk("rand_words", nx == NA, 64'(nx), 64'(NA));
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
